wb_stage_pipelined: RTL and testbench
=====================================

// Module: wb_stage_pipelined
// PURPOSE
//  Registered, parametrised write-back stage for the RV32I-MAF core. It sits between
//  MEM and the register file, and adds what the combinational write-back lacks:
//  - a valid/ready pipeline register
//  - a multi-cycle wait for data-memory load responses, with timeout
//  - byte/half/word load alignment and sign/zero extension
//  - a CSR source, x0 write suppression, a forwarding port and a retired-write counter.
// PARAMETERS
//  XLEN        32   datapath width
//  REG_AW      5    register-file address width
//  MEM_W       32   dmem response data width (== XLEN)
//  LD_TIMEOUT  16   max cycles in WAIT_LD before fault (>=1)
//  CNT_W       32   retired-write counter width
// PORTS
//  clk             in   1       core clock
//  rstn            in   1       asynchronous active-low reset
//  in_valid        in   1       MEM stage presents an instruction
//  in_ready        out  1       stage can accept (state==IDLE)
//  in_alu_data     in   XLEN    ALU result
//  in_pc_pls4      in   XLEN    PC+4 (JAL/JALR link value)
//  in_csr_data     in   XLEN    CSR read value
//  in_rd           in   REG_AW  destination register
//  in_reg_wr       in   1       instruction writes rd
//  in_wb_sel       in   2       0=ALU 1=MEM load 2=PC+4 3=CSR
//  in_ld_size      in   2       0=byte 1=half 2=word (3 reserved -> fault)
//  in_ld_unsigned  in   1       1=zero-extend, 0=sign-extend
//  in_addr_lsb     in   2       load address bits [1:0]
//  dmem_rsp_valid  in   1       load data valid (one-cycle pulse)
//  dmem_rsp_data   in   MEM_W   aligned memory word
//  dmem_rsp_err    in   1       bus error, qualified by dmem_rsp_valid
//  rf_wr_en        out  1       register-file write enable (registered)
//  rf_wr_addr      out  REG_AW  write address
//  rf_wr_data      out  XLEN    write data
//  fwd_valid       out  1       ==rf_wr_en; forwarding to EX
//  fwd_rd / fwd_data out REG_AW/XLEN  ==rf_wr_addr/rf_wr_data
//  load_fault      out  1       1-cycle pulse: misaligned, error, timeout or bad size
//  retired_cnt     out  CNT_W   count of rf_wr_en cycles; wraps to 0
// BEHAVIOUR
//  Reset (async, rstn=0):
//  - all outputs 0; state=IDLE; timeout counter=0; in_ready=0 while rstn=0
//  - any pending load is abandoned; a response arriving after reset is ignored.
//  Accept: in_valid&&in_ready at edge N. In_ready=1 only in IDLE, so back-to-back
//  non-loads are accepted every cycle.
//  Non-load (wb_sel!=1): rf_wr_en=1 in cycle N+1 (1-cycle latency), for exactly one cycle.
//  - rf_wr_en=0 if in_reg_wr=0 or in_rd==0 (x0 suppression).
//  Load (wb_sel==1): at acceptance, check alignment.
//  - Misaligned: half with lsb[0]=1, or word with lsb!=0.
//  - Misaligned or size==3: load_fault pulses in N+1, no write, stay IDLE.
//  - Otherwise go to WAIT_LD; in_ready=0; capture rd, size, unsigned, lsb.
//  WAIT_LD:
//  - dmem_rsp_valid is sampled only here, from cycle N+1 on; in IDLE it is ignored.
//  - Response in cycle M, err=0: rf_wr_en=1 in M+1 with formatted data; next state IDLE;
//    in_ready=1 in M+1.
//  - Response with err=1: load_fault pulse in M+1, no write, IDLE.
//  - Timeout: counter increments each WAIT_LD cycle without a response. On the cycle it
//    reaches LD_TIMEOUT: load_fault pulse next cycle, no write, IDLE.
//  Formatter:
//  - byte = data[8*lsb +:8]; half = data[16*lsb[1] +:16]; word = data.
//  - extend to XLEN: sign bit if in_ld_unsigned=0, zeros otherwise.
//  - x0 suppression also applies to loads (a fault is still reported).
//  retired_cnt: +1 on every cycle with rf_wr_en=1; wraps modulo 2^CNT_W.
//  States: IDLE, WAIT_LD only. Outputs are registered; no combinational in->out path.
// TESTING
//  1. ALU op, rd=5, data=0xDEADBEEF, accepted at N -> rf_wr_en=1, addr=5,
//     data=0xDEADBEEF at N+1 only; retired_cnt=1.
//  2. LB signed, lsb=3; rsp 0x80FF_0000 after 3 cycles -> write 0xFFFFFF80.
//     Same with LBU -> 0x00000080.
//  3. LH, lsb=1 -> load_fault at N+1, no write, in_ready stays 1.
//     LW, lsb=2 -> same.
//  4. LW with no response, LD_TIMEOUT=16 -> load_fault exactly once, after 16
//     WAIT_LD cycles; then IDLE; a later stray dmem_rsp_valid is ignored.
//  5. rd=0 with reg_wr=1 (ALU and load) -> rf_wr_en=0; retired_cnt unchanged.
//     PC+4 select 0x104 -> data 0x104. CSR select 0x1800 -> data 0x1800.
//  6. rstn low mid WAIT_LD -> outputs 0 immediately; after release, rsp_valid ignored.
//     Counter preloaded to 2^CNT_W-1 plus one write -> retired_cnt=0.

Source files
------------

// File: rtl/wb_stage_pipelined.sv
// Registered write-back stage between MEM and the register file: valid/ready pipeline
// register, load-response wait with timeout, load formatting, x0 suppression, retire count.
module wb_stage_pipelined #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int MEM_W      = 32,
    parameter int LD_TIMEOUT = 16,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_alu_data,
    input  logic [XLEN-1:0]   in_pc_pls4,
    input  logic [XLEN-1:0]   in_csr_data,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_wr,
    input  logic [1:0]        in_wb_sel,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [1:0]        in_addr_lsb,
    input  logic              dmem_rsp_valid,
    input  logic [MEM_W-1:0]  dmem_rsp_data,
    input  logic              dmem_rsp_err,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [XLEN-1:0]   rf_wr_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              load_fault,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic {IDLE = 1'b0, WAIT_LD = 1'b1} state_t;

    localparam int TW = $clog2(LD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LD_TIMEOUT - 1);

    state_t            state_r, state_s;
    logic [TW-1:0]     tmo_cnt_r, tmo_cnt_s;
    logic [REG_AW-1:0] ld_rd_r;
    logic              ld_wr_r;
    logic [1:0]        ld_size_r;
    logic              ld_uns_r;
    logic [1:0]        ld_lsb_r;

    logic              in_ready_r, rf_wr_en_r, load_fault_r;
    logic [REG_AW-1:0] rf_wr_addr_r;
    logic [XLEN-1:0]   rf_wr_data_r;
    logic [CNT_W-1:0]  retired_cnt_r;

    logic              accept_s, is_load_s, bad_ld_s, wr_en_s, fault_s;
    logic [REG_AW-1:0] wr_addr_s;
    logic [XLEN-1:0]   wr_data_s, sel_data_s;

    // Extract the addressed byte/half from the aligned word and extend it to XLEN.
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] d,
                                                 input logic [1:0] sz,
                                                 input logic uns,
                                                 input logic [1:0] lsb);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lsb, 3'b000} +: 8];
        h = d[{lsb[1], 4'b0000} +: 16];
        case (sz)
            2'd0:    fmt_load = {{(XLEN-8){~uns & b[7]}}, b};
            2'd1:    fmt_load = {{(XLEN-16){~uns & h[15]}}, h};
            default: fmt_load = d;
        endcase
    endfunction

    assign accept_s  = in_valid && in_ready_r;
    assign is_load_s = (in_wb_sel == 2'd1);
    assign bad_ld_s  = (in_ld_size == 2'd3) ||
                       ((in_ld_size == 2'd1) && in_addr_lsb[0]) ||
                       ((in_ld_size == 2'd2) && (in_addr_lsb != 2'd0));

    // Write-data source for non-load instructions.
    always_comb begin
        case (in_wb_sel)
            2'd2:    sel_data_s = in_pc_pls4;
            2'd3:    sel_data_s = in_csr_data;
            default: sel_data_s = in_alu_data;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: only a well-formed accepted load leaves IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_load_s && !bad_ld_s) state_s = WAIT_LD;
                else                                    state_s = IDLE;
            end
            WAIT_LD: begin
                if (dmem_rsp_valid || (tmo_cnt_r == TMO_LAST)) state_s = IDLE;
                else                                           state_s = WAIT_LD;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output logic: next values for the write port, fault pulse and timeout counter.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = rf_wr_addr_r;
        wr_data_s = rf_wr_data_r;
        fault_s   = 1'b0;
        tmo_cnt_s = tmo_cnt_r;
        case (state_r)
            IDLE: begin
                tmo_cnt_s = {TW{1'b0}};
                if (accept_s && is_load_s) begin
                    fault_s = bad_ld_s;
                end else if (accept_s) begin
                    wr_en_s   = in_reg_wr && (in_rd != {REG_AW{1'b0}});
                    wr_addr_s = in_rd;
                    wr_data_s = sel_data_s;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            WAIT_LD: begin
                if (dmem_rsp_valid) begin
                    tmo_cnt_s = {TW{1'b0}};
                    if (dmem_rsp_err) begin
                        fault_s = 1'b1;
                    end else begin
                        wr_en_s   = ld_wr_r && (ld_rd_r != {REG_AW{1'b0}});
                        wr_addr_s = ld_rd_r;
                        wr_data_s = fmt_load(dmem_rsp_data, ld_size_r, ld_uns_r, ld_lsb_r);
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_cnt_s = {TW{1'b0}};
                    fault_s   = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 1'b1;
                end
            end
            default: tmo_cnt_s = {TW{1'b0}};
        endcase
    end

    // Load context captured when a load enters WAIT_LD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_rd_r   <= {REG_AW{1'b0}};
            ld_wr_r   <= 1'b0;
            ld_size_r <= 2'd0;
            ld_uns_r  <= 1'b0;
            ld_lsb_r  <= 2'd0;
        end else if ((state_r == IDLE) && (state_s == WAIT_LD)) begin
            ld_rd_r   <= in_rd;
            ld_wr_r   <= in_reg_wr;
            ld_size_r <= in_ld_size;
            ld_uns_r  <= in_ld_unsigned;
            ld_lsb_r  <= in_addr_lsb;
        end else begin
            ld_rd_r   <= ld_rd_r;
            ld_wr_r   <= ld_wr_r;
            ld_size_r <= ld_size_r;
            ld_uns_r  <= ld_uns_r;
            ld_lsb_r  <= ld_lsb_r;
        end
    end

    // Registered outputs; in_ready is held low throughout reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_r     <= {TW{1'b0}};
            in_ready_r    <= 1'b0;
            rf_wr_en_r    <= 1'b0;
            rf_wr_addr_r  <= {REG_AW{1'b0}};
            rf_wr_data_r  <= {XLEN{1'b0}};
            load_fault_r  <= 1'b0;
            retired_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tmo_cnt_r    <= tmo_cnt_s;
            in_ready_r   <= (state_s == IDLE);
            rf_wr_en_r   <= wr_en_s;
            rf_wr_addr_r <= wr_addr_s;
            rf_wr_data_r <= wr_data_s;
            load_fault_r <= fault_s;
            if (wr_en_s) retired_cnt_r <= retired_cnt_r + 1'b1;
            else         retired_cnt_r <= retired_cnt_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign rf_wr_en    = rf_wr_en_r;
    assign rf_wr_addr  = rf_wr_addr_r;
    assign rf_wr_data  = rf_wr_data_r;
    assign fwd_valid   = rf_wr_en_r;
    assign fwd_rd      = rf_wr_addr_r;
    assign fwd_data    = rf_wr_data_r;
    assign load_fault  = load_fault_r;
    assign retired_cnt = retired_cnt_r;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Randomised self-checking bench for wb_stage_pipelined; a small counter width makes wrap reachable.
module tb_wb_stage_pipelined;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_alu_data, in_pc_pls4, in_csr_data;
    logic [4:0]    in_rd;
    logic          in_reg_wr;
    logic [1:0]    in_wb_sel, in_ld_size, in_addr_lsb;
    logic          in_ld_unsigned;
    logic          dmem_rsp_valid, dmem_rsp_err;
    logic [31:0]   dmem_rsp_data;
    logic          rf_wr_en, fwd_valid, load_fault;
    logic [4:0]    rf_wr_addr, fwd_rd;
    logic [31:0]   rf_wr_data, fwd_data;
    logic [CW-1:0] retired_cnt;

    int            chk_cnt = 0;
    int            pass_cnt = 0;
    logic [CW-1:0] exp_cnt;

    wb_stage_pipelined #(.XLEN(32), .REG_AW(5), .MEM_W(32), .LD_TIMEOUT(16), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_data(in_alu_data), .in_pc_pls4(in_pc_pls4), .in_csr_data(in_csr_data),
        .in_rd(in_rd), .in_reg_wr(in_reg_wr), .in_wb_sel(in_wb_sel), .in_ld_size(in_ld_size),
        .in_ld_unsigned(in_ld_unsigned), .in_addr_lsb(in_addr_lsb),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data), .dmem_rsp_err(dmem_rsp_err),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_fault(load_fault), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Reference load result: shift the word down to the addressed lane, mask, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] lsb);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (8 * lsb)) % 32'd256;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * (lsb / 2))) % 32'd65536;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic ref_bad(input logic [1:0] sz, input logic [1:0] lsb);
        return (sz == 2'd3) || (sz == 2'd1 && lsb % 2 == 1) || (sz == 2'd2 && lsb != 2'd0);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one clock edge.
    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic wr,
                         input logic [31:0] val, input logic [1:0] sz, input logic uns,
                         input logic [1:0] lsb);
        in_valid = 1'b1; in_wb_sel = sel; in_rd = rd; in_reg_wr = wr;
        in_alu_data = $urandom; in_pc_pls4 = $urandom; in_csr_data = $urandom;
        if (sel == 2'd0) in_alu_data = val;
        if (sel == 2'd2) in_pc_pls4 = val;
        if (sel == 2'd3) in_csr_data = val;
        in_ld_size = sz; in_ld_unsigned = uns; in_addr_lsb = lsb;
        cyc();
        in_valid = 1'b0; in_alu_data = $urandom; in_rd = 5'($urandom_range(0, 31));
    endtask

    // Wait `delay` idle cycles, then pulse one load response.
    task automatic load_rsp(input int delay, input logic [31:0] d, input logic err);
        repeat (delay) cyc();
        dmem_rsp_valid = 1'b1; dmem_rsp_data = d; dmem_rsp_err = err;
        cyc();
        dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0; dmem_rsp_data = $urandom;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_wb_sel = 2'd0; in_rd = 5'd0; in_reg_wr = 1'b0;
        in_alu_data = 32'd0; in_pc_pls4 = 32'd0; in_csr_data = 32'd0; in_ld_size = 2'd0;
        in_ld_unsigned = 1'b0; in_addr_lsb = 2'd0;
        dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0; dmem_rsp_data = 32'd0;
        exp_cnt = '0;
        repeat (2) cyc();
        chk_cnt++; if ({in_ready, rf_wr_en, load_fault, fwd_valid} !== 4'b0000)
            $display("FAIL reset_ctrl got=%b exp=0000", {in_ready, rf_wr_en, load_fault, fwd_valid}); else pass_cnt++;
        chk_cnt++; if ({rf_wr_addr, rf_wr_data, retired_cnt} !== '0)
            $display("FAIL reset_data got addr=%0d data=%h cnt=%0d exp=0", rf_wr_addr, rf_wr_data, retired_cnt); else pass_cnt++;
        @(negedge clk) rstn = 1'b1;
        cyc();
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else pass_cnt++;
    endtask

    task automatic test_alu();
        issue(2'd0, 5'd5, 1'b1, 32'hDEADBEEF, 2'd0, 1'b0, 2'd0);
        exp_cnt++;
        chk_cnt++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL alu_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data); else pass_cnt++;
        chk_cnt++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL alu_fwd got v=%b rd=%0d data=%h exp v=1 rd=5 data=deadbeef", fwd_valid, fwd_rd, fwd_data); else pass_cnt++;
        cyc();
        chk_cnt++; if (rf_wr_en !== 1'b0) $display("FAIL alu_one_cycle got=%b exp=0", rf_wr_en); else pass_cnt++;
        chk_cnt++; if (retired_cnt !== exp_cnt) $display("FAIL alu_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_load_ext();
        issue(2'd1, 5'd9, 1'b1, 32'd0, 2'd0, 1'b0, 2'd3);
        chk_cnt++; if ({in_ready, rf_wr_en} !== 2'b00)
            $display("FAIL lb_wait got ready=%b en=%b exp 0 0", in_ready, rf_wr_en); else pass_cnt++;
        load_rsp(2, 32'h80FF_0000, 1'b0);
        exp_cnt++;
        chk_cnt++; if ({rf_wr_en, rf_wr_addr, rf_wr_data, in_ready} !== {1'b1, 5'd9, 32'hFFFF_FF80, 1'b1})
            $display("FAIL lb_signed got en=%b addr=%0d data=%h rdy=%b exp 1 9 ffffff80 1", rf_wr_en, rf_wr_addr, rf_wr_data, in_ready); else pass_cnt++;
        // A response in the acceptance cycle itself must be ignored.
        dmem_rsp_valid = 1'b1; dmem_rsp_err = 1'b1;
        issue(2'd1, 5'd10, 1'b1, 32'd0, 2'd0, 1'b1, 2'd3);
        dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0;
        chk_cnt++; if ({rf_wr_en, load_fault, in_ready} !== 3'b000)
            $display("FAIL lbu_early_rsp got en=%b fault=%b rdy=%b exp 000", rf_wr_en, load_fault, in_ready); else pass_cnt++;
        load_rsp(1, 32'h80FF_0000, 1'b0);
        exp_cnt++;
        chk_cnt++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd10, 32'h0000_0080})
            $display("FAIL lbu got en=%b addr=%0d data=%h exp 1 10 00000080", rf_wr_en, rf_wr_addr, rf_wr_data); else pass_cnt++;
        cyc();
        chk_cnt++; if (rf_wr_en !== 1'b0) $display("FAIL lbu_one_cycle got=%b exp=0", rf_wr_en); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        logic [1:0] szs [3] = '{2'd1, 2'd2, 2'd3};
        logic [1:0] lsbs[3] = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            issue(2'd1, 5'd11, 1'b1, 32'd0, szs[i], 1'b0, lsbs[i]);
            chk_cnt++; if ({load_fault, rf_wr_en, in_ready} !== 3'b101)
                $display("FAIL misalign_%0d got fault=%b en=%b rdy=%b exp 1 0 1", i, load_fault, rf_wr_en, in_ready); else pass_cnt++;
            cyc();
            chk_cnt++; if (load_fault !== 1'b0) $display("FAIL misalign_pulse_%0d got=%b exp=0", i, load_fault); else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        issue(2'd1, 5'd12, 1'b1, 32'd0, 2'd2, 1'b0, 2'd0);
        while (load_fault !== 1'b1 && k < 40) begin
            cyc();
            k++;
        end
        chk_cnt++; if (k != 16) $display("FAIL timeout_latency got=%0d exp=16", k); else pass_cnt++;
        chk_cnt++; if ({in_ready, rf_wr_en} !== 2'b10)
            $display("FAIL timeout_state got rdy=%b en=%b exp 1 0", in_ready, rf_wr_en); else pass_cnt++;
        cyc();
        chk_cnt++; if (load_fault !== 1'b0) $display("FAIL timeout_once got=%b exp=0", load_fault); else pass_cnt++;
        load_rsp(0, 32'h1234_5678, 1'b0);
        chk_cnt++; if ({rf_wr_en, load_fault} !== 2'b00)
            $display("FAIL stray_rsp got en=%b fault=%b exp 0 0", rf_wr_en, load_fault); else pass_cnt++;
    endtask

    task automatic test_x0_sel();
        issue(2'd0, 5'd0, 1'b1, 32'hCAFE_0001, 2'd0, 1'b0, 2'd0);
        chk_cnt++; if (rf_wr_en !== 1'b0) $display("FAIL x0_alu got=%b exp=0", rf_wr_en); else pass_cnt++;
        issue(2'd1, 5'd0, 1'b1, 32'd0, 2'd2, 1'b0, 2'd0);
        load_rsp(0, 32'h1234_5678, 1'b0);
        chk_cnt++; if ({rf_wr_en, load_fault} !== 2'b00)
            $display("FAIL x0_load got en=%b fault=%b exp 0 0", rf_wr_en, load_fault); else pass_cnt++;
        issue(2'd2, 5'd7, 1'b1, 32'h0000_0104, 2'd0, 1'b0, 2'd0);
        exp_cnt++;
        chk_cnt++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd7, 32'h0000_0104})
            $display("FAIL pc4_sel got en=%b addr=%0d data=%h exp 1 7 00000104", rf_wr_en, rf_wr_addr, rf_wr_data); else pass_cnt++;
        issue(2'd3, 5'd8, 1'b1, 32'h0000_1800, 2'd0, 1'b0, 2'd0);
        exp_cnt++;
        chk_cnt++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd8, 32'h0000_1800})
            $display("FAIL csr_sel got en=%b addr=%0d data=%h exp 1 8 00001800", rf_wr_en, rf_wr_addr, rf_wr_data); else pass_cnt++;
        issue(2'd0, 5'd6, 1'b0, 32'h5555_AAAA, 2'd0, 1'b0, 2'd0);
        chk_cnt++; if (rf_wr_en !== 1'b0) $display("FAIL no_reg_wr got=%b exp=0", rf_wr_en); else pass_cnt++;
        cyc();
        chk_cnt++; if (retired_cnt !== exp_cnt) $display("FAIL x0_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic [1:0] sel = 2'($urandom_range(0, 3));
            logic [4:0] rd = 5'($urandom_range(0, 31));
            logic wr = ($urandom_range(0, 3) != 0);
            logic [31:0] val = $urandom;
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic [1:0] lsb = 2'($urandom_range(0, 3));
            logic uns = 1'($urandom_range(0, 1));
            logic exp_wr = wr && (rd != 5'd0);
            issue(sel, rd, wr, val, sz, uns, lsb);
            if (sel != 2'd1) begin
                chk_cnt++; if (rf_wr_en !== exp_wr || (exp_wr && {rf_wr_addr, rf_wr_data} !== {rd, val}))
                    $display("FAIL rnd_nl_%0d got en=%b addr=%0d data=%h exp en=%b addr=%0d data=%h", t, rf_wr_en, rf_wr_addr, rf_wr_data, exp_wr, rd, val); else pass_cnt++;
                if (exp_wr) exp_cnt++;
            end else if (ref_bad(sz, lsb)) begin
                chk_cnt++; if ({load_fault, rf_wr_en} !== 2'b10)
                    $display("FAIL rnd_bad_%0d got fault=%b en=%b exp 1 0", t, load_fault, rf_wr_en); else pass_cnt++;
            end else begin
                logic err = ($urandom_range(0, 7) == 0);
                logic [31:0] d = $urandom;
                load_rsp($urandom_range(0, 5), d, err);
                if (err) begin
                    chk_cnt++; if ({load_fault, rf_wr_en} !== 2'b10)
                        $display("FAIL rnd_err_%0d got fault=%b en=%b exp 1 0", t, load_fault, rf_wr_en); else pass_cnt++;
                end else begin
                    chk_cnt++; if (load_fault !== 1'b0 || rf_wr_en !== exp_wr ||
                                   (exp_wr && {rf_wr_addr, rf_wr_data} !== {rd, ref_load(d, sz, uns, lsb)}))
                        $display("FAIL rnd_ld_%0d got en=%b addr=%0d data=%h exp en=%b addr=%0d data=%h", t, rf_wr_en, rf_wr_addr, rf_wr_data, exp_wr, rd, ref_load(d, sz, uns, lsb)); else pass_cnt++;
                    if (exp_wr) exp_cnt++;
                end
            end
        end
        cyc();
        chk_cnt++; if (retired_cnt !== exp_cnt) $display("FAIL rnd_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_load();
        issue(2'd1, 5'd13, 1'b1, 32'd0, 2'd2, 1'b0, 2'd0);
        repeat (2) cyc();
        #2 rstn = 1'b0;
        #1;
        exp_cnt = '0;
        chk_cnt++; if ({in_ready, rf_wr_en, load_fault, rf_wr_addr, rf_wr_data, retired_cnt} !== '0)
            $display("FAIL reset_async got rdy=%b en=%b fault=%b addr=%0d data=%h cnt=%0d exp all 0", in_ready, rf_wr_en, load_fault, rf_wr_addr, rf_wr_data, retired_cnt); else pass_cnt++;
        @(negedge clk) rstn = 1'b1;
        cyc();
        load_rsp(0, 32'hFFFF_FFFF, 1'b1);
        chk_cnt++; if ({rf_wr_en, load_fault, in_ready} !== 3'b001)
            $display("FAIL reset_stale_rsp got en=%b fault=%b rdy=%b exp 0 0 1", rf_wr_en, load_fault, in_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back_wrap();
        for (int i = 0; i < 15; i++) begin
            issue(2'd0, 5'(i + 1), 1'b1, 32'h0100_0000 + 32'(i), 2'd0, 1'b0, 2'd0);
            exp_cnt++;
            chk_cnt++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'(i + 1), 32'h0100_0000 + 32'(i)})
                $display("FAIL b2b_%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d", i, rf_wr_en, rf_wr_addr, rf_wr_data, i + 1); else pass_cnt++;
        end
        cyc();
        chk_cnt++; if (retired_cnt !== 4'd15) $display("FAIL cnt_full got=%0d exp=15", retired_cnt); else pass_cnt++;
        issue(2'd0, 5'd31, 1'b1, 32'h0000_0001, 2'd0, 1'b0, 2'd0);
        exp_cnt++;
        cyc();
        chk_cnt++; if (retired_cnt !== exp_cnt || retired_cnt !== 4'd0)
            $display("FAIL cnt_wrap got=%0d exp=0", retired_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_misaligned();
        test_timeout();
        test_x0_sel();
        test_random();
        test_reset_mid_load();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
